// File: rtl/pipeline_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use, mult/div busy, data-memory wait, taken-branch flush.
// Optional stall statistic counters are enabled with `define PIPELINE_STALL_STATS_EN.
module pipeline_stall_ctrl #(
  parameter int unsigned MD_LATENCY = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [4:0]           rsID,
  input  logic [4:0]           rtID,
  input  logic [4:0]           rtEX,
  input  logic                 memReadEX,
  input  logic                 branchTaken,
  input  logic                 hiloReadID,
  input  logic                 mdStart,
  input  logic                 memReqMEM,
  input  logic                 dmemReady,
  output logic                 pcWrite,
  output logic                 ifIdWrite,
  output logic                 idExWrite,
  output logic                 exMemWrite,
  output logic                 ifIdFlush,
  output logic                 idExFlush,
  output logic                 memWbFlush,
  output logic                 mdBusy,
  output logic                 stalled
`ifdef PIPELINE_STALL_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] loadStallCnt,
  output logic [CNT_WIDTH-1:0] mdStallCnt,
  output logic [CNT_WIDTH-1:0] memStallCnt,
  output logic [CNT_WIDTH-1:0] flushCnt
`endif
);

  typedef enum logic {RUN, MD_BUSY} state_t;

  localparam logic [7:0] MD_RELOAD = 8'(MD_LATENCY - 1);

  state_t     state_q, state_d;
  logic [7:0] mdCnt_q, mdCnt_d;
  logic       loadUse, memWait, mdHazard, mdIssue;

  assign loadUse  = memReadEX && (rtEX != 5'd0) && ((rsID == rtEX) || (rtID == rtEX));
  assign memWait  = memReqMEM && !dmemReady;
  assign mdBusy   = (state_q == MD_BUSY);
  assign mdHazard = mdBusy && hiloReadID;
  // A frozen EX stage will present the same mult/div again, so ignore it now
  assign mdIssue  = mdStart && !memWait;
  assign stalled  = memWait || mdHazard || loadUse;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= RUN;
      mdCnt_q <= 8'd0;
    end else begin
      state_q <= state_d;
      mdCnt_q <= mdCnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mdCnt_d = mdCnt_q;
    unique case (state_q)
      RUN: begin
        if (mdIssue) begin
          state_d = MD_BUSY;
          mdCnt_d = MD_RELOAD;
        end
      end
      MD_BUSY: begin
        if (mdIssue) begin
          mdCnt_d = MD_RELOAD;
        end else if (mdCnt_q == 8'd0) begin
          state_d = RUN;
        end else begin
          mdCnt_d = mdCnt_q - 8'd1;
        end
      end
      default: begin
        state_d = RUN;
        mdCnt_d = 8'd0;
      end
    endcase
  end

  always_comb begin
    pcWrite    = 1'b1;
    ifIdWrite  = 1'b1;
    idExWrite  = 1'b1;
    exMemWrite = 1'b1;
    ifIdFlush  = 1'b0;
    idExFlush  = 1'b0;
    memWbFlush = 1'b0;
    if (memWait) begin
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      idExWrite  = 1'b0;
      exMemWrite = 1'b0;
      memWbFlush = 1'b1;
    end else if (mdHazard || loadUse) begin
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      idExFlush  = 1'b1;
    end else if (branchTaken) begin
      ifIdFlush  = 1'b1;
    end
  end

`ifdef PIPELINE_STALL_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] loadStallCnt_q, mdStallCnt_q, memStallCnt_q, flushCnt_q;

  // Only the highest-priority active cause is charged each cycle
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      loadStallCnt_q <= '0;
      mdStallCnt_q   <= '0;
      memStallCnt_q  <= '0;
      flushCnt_q     <= '0;
    end else if (memWait) begin
      if (memStallCnt_q != '1) memStallCnt_q <= memStallCnt_q + CNT_ONE;
    end else if (mdHazard) begin
      if (mdStallCnt_q != '1) mdStallCnt_q <= mdStallCnt_q + CNT_ONE;
    end else if (loadUse) begin
      if (loadStallCnt_q != '1) loadStallCnt_q <= loadStallCnt_q + CNT_ONE;
    end else if (branchTaken) begin
      if (flushCnt_q != '1) flushCnt_q <= flushCnt_q + CNT_ONE;
    end
  end

  assign loadStallCnt = loadStallCnt_q;
  assign mdStallCnt   = mdStallCnt_q;
  assign memStallCnt  = memStallCnt_q;
  assign flushCnt     = flushCnt_q;
`endif

endmodule

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 SHALL have parameter MD_LATENCY, default 32: mult/div unit latency in cycles, range 2..255.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of each stall statistic counter.
REQ-003 SHALL have port Clock  input  1  single system clock, rising-edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports rsID, rtID  input  5 each  source registers of the instruction in ID.
REQ-006 SHALL have ports rtEX  input  5 and memReadEX  input  1  destination and load flag of the instruction in EX.
REQ-007 SHALL have ports branchTaken  input  1 and hiloReadID  input  1  taken branch/jump resolved in ID; ID instruction reads HI/LO.
REQ-008 SHALL have ports mdStart  input  1 and memReqMEM  input  1 and dmemReady  input  1  mult/div issue in EX; MEM-stage data access; data memory ready.
REQ-009 SHALL have ports pcWrite, ifIdWrite, idExWrite, exMemWrite  output  1 each  stage register enables, 1 = advance.
REQ-010 SHALL have ports ifIdFlush, idExFlush, memWbFlush  output  1 each  active-high bubble inserts.
REQ-011 SHALL have ports mdBusy  output  1 and stalled  output  1  mult/div in flight; any stall this cycle.

Function
REQ-012 SHALL define loadUse = memReadEX && rtEX!=0 && (rsID==rtEX || rtID==rtEX).
REQ-013 SHALL define memWait = memReqMEM && !dmemReady.
REQ-014 SHALL implement registered FSM with states RUN and MD_BUSY plus an 8-bit down-counter mdCnt.
REQ-015 SHALL, in RUN, on mdStart && !memWait, load mdCnt = MD_LATENCY-1 and go to MD_BUSY next cycle.
REQ-016 SHALL, in MD_BUSY, decrement mdCnt every cycle regardless of stalls and return to RUN the cycle after mdCnt reaches 0.
REQ-017 SHALL, on mdStart in MD_BUSY, reload mdCnt = MD_LATENCY-1 and remain in MD_BUSY.
REQ-018 SHALL drive mdBusy = 1 exactly when state is MD_BUSY.
REQ-019 SHALL define mdHazard = mdBusy && hiloReadID.
REQ-020 SHALL apply priority memWait > mdHazard > loadUse > branchTaken; outputs are combinational from state and inputs.
REQ-021 SHALL, on memWait: all four write enables 0, memWbFlush 1, other flushes 0.
REQ-022 SHALL, on mdHazard or loadUse (no memWait): pcWrite 0, ifIdWrite 0, idExFlush 1, idExWrite/exMemWrite 1.
REQ-023 SHALL, on branchTaken with no stall: all enables 1, ifIdFlush 1.
REQ-024 SHALL suppress ifIdFlush whenever any stall is active; branch is re-evaluated when ID advances.
REQ-025 SHALL, with no condition active: all enables 1, all flushes 0.
REQ-026 SHALL drive stalled = memWait || mdHazard || loadUse.
REQ-027 SHALL ignore mdStart while memWait is 1 (EX instruction frozen, re-presented later).

Reset
REQ-028 SHALL on Reset low asynchronously force state RUN, mdCnt 0, statistic counters 0.
REQ-029 SHALL hold mdBusy 0 during reset; other outputs follow REQ-020..026 from inputs.
REQ-030 SHALL abort any in-flight mult/div count on reset mid-operation; first cycle after release is RUN.

Configuration
REQ-031 SHALL, with macro PIPELINE_STALL_STATS_EN defined, add outputs loadStallCnt, mdStallCnt, memStallCnt, flushCnt (CNT_WIDTH each).
REQ-032 SHALL increment each counter once per cycle its condition is the winning cause per REQ-020, saturating at all-ones.
REQ-033 SHALL, without PIPELINE_STALL_STATS_EN, omit those ports and counters entirely; all other behaviour identical.

Verification
REQ-034 SHALL cover load-use: memReadEX=1, rtEX=5'b01111, rsID=5'b01111 -> pcWrite=0, ifIdWrite=0, idExFlush=1, stalled=1 for that cycle.
REQ-035 SHALL cover $zero: memReadEX=1, rtEX=0, rsID=0 -> pcWrite=1, stalled=0.
REQ-036 SHALL cover mult/div: MD_LATENCY=4, mdStart one cycle, hiloReadID=1 held -> mdBusy=1 exactly 4 cycles, pcWrite=0 throughout, pcWrite=1 the cycle mdBusy falls.
REQ-037 SHALL cover priority: memWait=1 with loadUse=1 and branchTaken=1 -> all enables 0, memWbFlush=1, idExFlush=0, ifIdFlush=0.
REQ-038 SHALL cover branch: branchTaken=1, no hazards -> ifIdFlush=1, pcWrite=1; branchTaken with loadUse -> ifIdFlush=0.
REQ-039 SHALL cover reset mid-MD: Reset low at mdCnt=2 -> mdBusy=0 immediately, RUN after release; with PIPELINE_STALL_STATS_EN, counters read 0.
